// File: rtl/tdm_demux_pkg.sv
// Shared constants for the TDM demux scanner: FSM state encoding and slot indices.
package tdm_demux_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;

    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;

endpackage

// File: rtl/tdm_demux_scanner_settle_timer.sv
// Settle down-counter: load primes SETTLE_CYCLES-1, tick counts toward zero, done flags zero.
module settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic tick,
    output logic done
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/tdm_demux_scanner.sv
// Scans an external 4:1 mux via s1/s2 and rebuilds its four channels from din.
// Build option: TDM_DEMUX_SHADOW_EN publishes all four channels together at frame end.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting for en; selects parked on slot A
// ST_SETTLE | select driven, waiting SETTLE_CYCLES for the external mux
// ST_SAMPLE | capture din into the current slot, then advance or finish frame
module tdm_demux_scanner
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic             s1,
    output logic             s2,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] c_out,
    output logic [WIDTH-1:0] d_out,
    output logic             frame_valid,
    output logic             busy
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [1:0] slot;
    logic [1:0] slot_nxt;
    logic       timer_load;
    logic       timer_tick;
    logic       timer_done;
    logic       capture;
    logic       frame_end;

    logic [WIDTH-1:0] ch_q [4];

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk (clk),
        .rst (rst),
        .load(timer_load),
        .tick(timer_tick),
        .done(timer_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (en) state_nxt = ST_SETTLE;
            ST_SETTLE: if (timer_done) state_nxt = ST_SAMPLE;
            ST_SAMPLE: begin
                // en only matters at the frame boundary; mid-frame the scan always completes
                if ((slot != SLOT_D) || en) state_nxt = ST_SETTLE;
                else                        state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        slot_nxt   = slot;
        timer_load = 1'b0;
        timer_tick = 1'b0;
        capture    = 1'b0;
        frame_end  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    slot_nxt   = SLOT_A;
                    timer_load = 1'b1;
                end
            end
            ST_SETTLE: timer_tick = 1'b1;
            ST_SAMPLE: begin
                capture    = 1'b1;
                timer_load = 1'b1;
                if (slot == SLOT_D) begin
                    frame_end = 1'b1;
                    slot_nxt  = SLOT_A;
                end else begin
                    slot_nxt  = slot + 2'd1;
                end
            end
            default: slot_nxt = SLOT_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot        <= SLOT_A;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            slot        <= slot_nxt;
            frame_valid <= frame_end;
            busy        <= (state_nxt != ST_IDLE);
        end
    end

`ifdef TDM_DEMUX_SHADOW_EN
    logic [WIDTH-1:0] shadow_q [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
                ch_q[i]     <= '0;
            end
        end else begin
            if (capture) shadow_q[slot] <= din;
            // slot D is captured on this same edge, so it bypasses its shadow
            if (frame_end) begin
                ch_q[SLOT_A] <= shadow_q[SLOT_A];
                ch_q[SLOT_B] <= shadow_q[SLOT_B];
                ch_q[SLOT_C] <= shadow_q[SLOT_C];
                ch_q[SLOT_D] <= din;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                ch_q[i] <= '0;
            end
        end else if (capture) begin
            ch_q[slot] <= din;
        end
    end
`endif

    assign s1    = slot[0];
    assign s2    = slot[1];
    assign a_out = ch_q[SLOT_A];
    assign b_out = ch_q[SLOT_B];
    assign c_out = ch_q[SLOT_C];
    assign d_out = ch_q[SLOT_D];

endmodule
